mem_block_master: RTL and testbench
===================================

Name: mem_block_master

Overview:
- Initiator-side controller for the 512 x 32-bit block memory.
- Drives the memory's WE, 9-bit address and 512-bit write bus, and captures its 512-bit registered read bus.
- Accepts read or write burst commands of 1-16 consecutive 16-word blocks over valid/ready handshakes.
- Sits between the compute datapath and the memory, so no datapath block touches memory timing directly.

Parameters:
- ADDR_W, 9, memory word-address width (depth 2**ADDR_W = 512).
- WORD_W, 32, bits per memory word.
- WORDS, 16, words per block; data bus width DW = WORDS*WORD_W = 512.
- LEN_W, 4, command length field width; blocks per burst = cmd_len+1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  starting word address.
- cmd_len  in  LEN_W  block count minus one.
- wdata_valid  in  1  write block available.
- wdata_ready  out  1  high only in WR_DATA.
- wdata  in  DW  write block; word i at bits [32i+:32].
- rdata_valid  out  1  read block held on rdata.
- rdata_ready  in  1  consumer accepts rdata.
- rdata  out  DW  captured read block.
- rdata_last  out  1  qualifies the final block of the burst.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last block completes.
- mem_we  out  1  memory write enable.
- mem_address  out  ADDR_W  memory block address.
- mem_in  out  DW  memory write data.
- mem_out  in  DW  memory read data; registered in memory on rising clk.

Behaviour:
- Reset (async, active-low):
  - State IDLE.
  - All outputs 0 except cmd_ready = 1.
  - Internal address and block counter cleared.
  - Reset mid-burst abandons the burst: no done, and mem_we drops immediately.
- All outputs are registered; nothing is combinational from inputs.
- States: IDLE, WR_DATA, WR_PULSE, RD_ADDR, RD_CAP, RD_OUT, DONE.
- IDLE: on cmd_valid and cmd_ready at an edge:
  - latch addr <= cmd_addr, remaining <= cmd_len;
  - drive mem_address <= cmd_addr;
  - go to WR_DATA if cmd_write, else RD_ADDR.
- WR_DATA:
  - wdata_ready = 1, mem_we = 0.
  - On wdata_valid: mem_in <= wdata, mem_we <= 1, go to WR_PULSE.
  - Waits indefinitely while wdata_valid is low.
- WR_PULSE:
  - mem_we is high for exactly this one cycle; mem_address and mem_in are stable for the whole cycle so the memory's falling-edge write sees them.
  - Next edge: mem_we <= 0.
  - If remaining == 0, go to DONE.
  - Otherwise addr <= (addr+16) mod 512, mem_address updated, remaining decremented, go to WR_DATA.
- RD_ADDR: one cycle with mem_address = addr and mem_we = 0. The memory registers mem_out at the edge ending this cycle. Go to RD_CAP.
- RD_CAP:
  - At the next edge: rdata <= mem_out, rdata_valid <= 1, rdata_last <= (remaining == 0).
  - Go to RD_OUT.
- RD_OUT:
  - rdata, rdata_valid and rdata_last are held stable until rdata_ready is high at an edge.
  - Then rdata_valid <= 0.
  - If last, go to DONE.
  - Otherwise advance addr and remaining as in WR_PULSE, go to RD_ADDR.
- Read latency: first rdata_valid is asserted 2 cycles after the command-accept edge. Per-block throughput is 3 cycles with rdata_ready held high.
- DONE: done = 1 for one cycle, then IDLE. cmd_ready returns 1 the cycle after DONE.
- Address wrap: addr advances by 16 modulo 512 (9-bit natural overflow). Any unaligned start is allowed. The memory wraps words within a block itself.
- mem_we is never high outside WR_PULSE. mem_address changes only on state transitions listed above.
- cmd_* inputs are ignored while busy. wdata is ignored outside WR_DATA; rdata_ready is ignored outside RD_OUT.

Test Plan:
- Single write then read:
  - Stimulus: write cmd_addr=0x020, cmd_len=0, wdata words i = 0x1000+i; then read the same address.
  - Required: exactly one mem_we pulse with mem_address=0x020; rdata equals the written block with rdata_last=1; one done pulse per command.
- Burst write, len=3, addr=0x1F0:
  - Required: mem_address sequence 0x1F0, 0x000, 0x010, 0x020 (wrap); 4 mem_we pulses, each one cycle; done 1 cycle after the 4th.
- Read backpressure:
  - Stimulus: read len=1 with rdata_ready low for 5 cycles per block.
  - Required: rdata stays stable and rdata_valid stays high throughout; mem_address does not advance until the handshake; rdata_last=1 only on block 2.
- Write stall:
  - Stimulus: wdata_valid withheld 7 cycles.
  - Required: wdata_ready stays high, mem_we stays 0, busy stays 1 for the whole stall.
- Reset mid-burst:
  - Stimulus: assert reset during WR_PULSE of block 2 of 4.
  - Required: mem_we falls without waiting for a clock; state IDLE, cmd_ready=1, no done; a following command runs normally from its own cmd_addr.
- Command ignored while busy:
  - Stimulus: cmd_valid pulsed with a different address mid-read.
  - Required: the burst completes unchanged and the second command is not captured.

Source files
------------

// File: rtl/mem_block_master.sv
// mem_block_master
// Initiator-side controller for a 512 x 32-bit block memory. It accepts read
// or write burst commands of 1..16 consecutive 16-word blocks over a
// valid/ready handshake and drives the memory's write enable, block address
// and 512-bit write bus. It also captures the memory's registered 512-bit
// read bus.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only when idle)
//   cmd_write            1 = write burst, 0 = read burst
//   cmd_addr, cmd_len    start word address, block count minus one
//   wdata_valid/ready    write block handshake; wdata word i at [32i+:32]
//   rdata_valid/ready    read block handshake; rdata held until accepted
//   rdata, rdata_last    captured read block, final-block qualifier
//   busy, done           not-idle flag, one-cycle completion pulse
//   mem_we, mem_address  memory write enable and block address
//   mem_in, mem_out      memory write data, memory registered read data
module mem_block_master #(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 32,
  parameter int WORDS  = 16,
  parameter int LEN_W  = 4,
  localparam int DW    = WORDS * WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DW-1:0]     wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DW-1:0]     rdata,
  output logic              rdata_last,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DW-1:0]     mem_in,
  input  logic [DW-1:0]     mem_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_PULSE,
    S_RD_ADDR,
    S_RD_CAP,
    S_RD_OUT,
    S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W-1:0]  addr_inc;
  logic [LEN_W-1:0]   remaining;

  // Block step wraps naturally at the top of the address space.
  assign addr_inc    = addr + ADDR_W'(WORDS);
  assign mem_address = addr;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (cmd_valid) state_nx = cmd_write ? S_WR_DATA : S_RD_ADDR;
      S_WR_DATA:  if (wdata_valid) state_nx = S_WR_PULSE;
      S_WR_PULSE: state_nx = (remaining == '0) ? S_DONE : S_WR_DATA;
      S_RD_ADDR:  state_nx = S_RD_CAP;
      S_RD_CAP:   state_nx = S_RD_OUT;
      S_RD_OUT:   if (rdata_ready) state_nx = rdata_last ? S_DONE : S_RD_ADDR;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Control flags are registered decodes of the next state, so every output
  // comes straight from a flop and reset clears mem_we without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_we      <= 1'b0;
    end else begin
      state       <= state_nx;
      cmd_ready   <= (state_nx == S_IDLE);
      wdata_ready <= (state_nx == S_WR_DATA);
      busy        <= (state_nx != S_IDLE);
      done        <= (state_nx == S_DONE);
      mem_we      <= (state_nx == S_WR_PULSE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr        <= '0;
      remaining   <= '0;
      mem_in      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
          end
        end
        S_WR_DATA: begin
          if (wdata_valid) mem_in <= wdata;
        end
        S_WR_PULSE: begin
          if (remaining != '0) begin
            addr      <= addr_inc;
            remaining <= remaining - 1'b1;
          end
        end
        S_RD_CAP: begin
          // Memory registered mem_out at the edge that ended RD_ADDR.
          rdata       <= mem_out;
          rdata_valid <= 1'b1;
          rdata_last  <= (remaining == '0);
        end
        S_RD_OUT: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            if (!rdata_last) begin
              addr      <= addr_inc;
              remaining <= remaining - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_master.sv
`timescale 1ns/1ps
module tb_mem_block_master;
  localparam int ADDR_W = 9;
  localparam int WORD_W = 32;
  localparam int WORDS  = 16;
  localparam int LEN_W  = 4;
  localparam int DW     = WORDS * WORD_W;

  logic              clk;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wdata_valid, wdata_ready;
  logic [DW-1:0]     wdata;
  logic              rdata_valid, rdata_ready, rdata_last;
  logic [DW-1:0]     rdata;
  logic              busy, done, mem_we;
  logic [ADDR_W-1:0] mem_address;
  logic [DW-1:0]     mem_in, mem_out;

  mem_block_master #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS(WORDS), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .busy(busy), .done(done),
    .mem_we(mem_we), .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block memory: registered read on rising edge, write on falling edge.
  logic [31:0] mem_arr [512];
  always @(posedge clk)
    for (int i = 0; i < WORDS; i++)
      mem_out[i*32 +: 32] <= mem_arr[(int'(mem_address) + i) % 512];
  always @(negedge clk)
    if (mem_we)
      for (int i = 0; i < WORDS; i++)
        mem_arr[(int'(mem_address) + i) % 512] = mem_in[i*32 +: 32];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: expected transactions derived from the commands issued.
  typedef struct packed { logic [8:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { logic [DW-1:0] d; logic last; } rd_t;
  wr_t         exp_wr[$];
  rd_t         exp_rd[$];
  logic [8:0]  we_log[$];
  logic [31:0] shadow [512];
  int          exp_done  = 0;
  int          done_seen = 0;
  int          last_evt  = 0;
  int          exp_rise  = 0;
  logic        prev_we   = 1'b0;
  logic        prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] make_blk(input int base);
    logic [DW-1:0] b;
    for (int i = 0; i < WORDS; i++) b[i*32 +: 32] = 32'(base + i);
    return b;
  endfunction

  function automatic logic [DW-1:0] shadow_blk(input int a);
    logic [DW-1:0] b;
    for (int i = 0; i < WORDS; i++) b[i*32 +: 32] = shadow[(a + i) % 512];
    return b;
  endfunction

  // Compare process
  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) begin
        chki("we_one_cycle", int'(prev_we), 0);
        if (exp_wr.size() == 0) chki("unexpected_we", 1, 0);
        else begin
          chki("wr_addr", int'(mem_address), int'(exp_wr[0].a));
          chk("wr_data", mem_in, exp_wr[0].d);
          void'(exp_wr.pop_front());
        end
        we_log.push_back(mem_address);
        last_evt = cyc;
      end
      if (rdata_valid) begin
        if (exp_rd.size() == 0) chki("unexpected_rvalid", 1, 0);
        else begin
          if (!prev_valid) chki("rd_latency", cyc, exp_rise);
          chk("rdata", rdata, exp_rd[0].d);
          chki("rdata_last", int'(rdata_last), int'(exp_rd[0].last));
          if (rdata_ready) begin
            void'(exp_rd.pop_front());
            last_evt = cyc;
            exp_rise = cyc + 3;
          end
        end
      end
      if (done) begin
        chki("done_expected", int'(exp_done > 0), 1);
        chki("done_timing", cyc, last_evt + 1);
        if (exp_done > 0) exp_done--;
        done_seen++;
      end
      prev_we    = mem_we;
      prev_valid = rdata_valid;
    end else begin
      prev_we    = 1'b0;
      prev_valid = 1'b0;
    end
  end

  task automatic issue_cmd(input logic w, input logic [8:0] a, input logic [3:0] l, output int acc);
    int t = 0;
    while (!cmd_ready && t < 100) begin @(posedge clk); #1; t++; end
    chki("cmd_ready_wait", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    chki("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_done > 0 && t < 200) begin @(posedge clk); #1; t++; end
    chki("done_wait", exp_done, 0);
  endtask

  task automatic feed_block(input logic [DW-1:0] blk, input int stall);
    int t = 0;
    while (!wdata_ready && t < 100) begin @(posedge clk); #1; t++; end
    chki("wdata_ready_wait", int'(wdata_ready), 1);
    for (int s = 0; s < stall; s++) begin
      chki("stall_wready", int'(wdata_ready), 1);
      chki("stall_we", int'(mem_we), 0);
      chki("stall_busy", int'(busy), 1);
      @(posedge clk); #1;
    end
    wdata = blk; wdata_valid = 1'b1;
    @(posedge clk); #1;
    wdata_valid = 1'b0;
  endtask

  task automatic do_write(input logic [8:0] a, input int len, input int base, input int stall);
    int acc;
    for (int b = 0; b <= len; b++) begin
      exp_wr.push_back(wr_t'{9'(int'(a) + 16*b), make_blk(base + 16*b)});
      for (int i = 0; i < WORDS; i++) shadow[(int'(a) + 16*b + i) % 512] = 32'(base + 16*b + i);
    end
    exp_done++;
    issue_cmd(1'b1, a, 4'(len), acc);
    for (int b = 0; b <= len; b++) feed_block(make_blk(base + 16*b), stall);
    wait_done();
  endtask

  task automatic do_read(input logic [8:0] a, input int len, input int delay, input bit poke,
                         output logic [DW-1:0] first_blk);
    int acc;
    logic [8:0] snap;
    first_blk = '0;
    for (int b = 0; b <= len; b++) exp_rd.push_back(rd_t'{shadow_blk(int'(a) + 16*b), b == len});
    exp_done++;
    issue_cmd(1'b0, a, 4'(len), acc);
    exp_rise = acc + 2;
    if (poke) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a ^ 9'h155; cmd_len = 4'd7;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    for (int b = 0; b <= len; b++) begin
      int t = 0;
      while (!rdata_valid && t < 50) begin @(posedge clk); #1; t++; end
      chki("rvalid_wait", int'(rdata_valid), 1);
      if (b == 0) first_blk = rdata;
      snap = mem_address;
      for (int s = 0; s < delay; s++) begin
        chki("bp_rvalid", int'(rdata_valid), 1);
        chki("bp_addr", int'(mem_address), int'(snap));
        @(posedge clk); #1;
      end
      rdata_ready = 1'b1;
      @(posedge clk); #1;
      rdata_ready = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    logic [DW-1:0] blk;
    int acc, d0;
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    for (int j = 0; j < 512; j++) begin
      mem_arr[j] = 32'hA500_0000 | 32'(j);
      shadow[j]  = 32'hA500_0000 | 32'(j);
    end
    repeat (3) @(posedge clk);
    #1;
    chki("rst_cmd_ready", int'(cmd_ready), 1);
    chki("rst_busy", int'(busy), 0);
    chki("rst_done", int'(done), 0);
    chki("rst_we", int'(mem_we), 0);
    chki("rst_wready", int'(wdata_ready), 0);
    chki("rst_rvalid", int'(rdata_valid), 0);
    chki("rst_addr", int'(mem_address), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single write then read
    do_write(9'h020, 0, 32'h1000, 0);
    chki("lit_mem020", int'(mem_arr[9'h020]), 32'h1000);
    chki("lit_mem02f", int'(mem_arr[9'h02F]), 32'h100F);
    do_read(9'h020, 0, 0, 0, blk);
    chki("lit_rd_w0", int'(blk[31:0]), 32'h1000);
    chki("lit_rd_w15", int'(blk[511:480]), 32'h100F);
    chki("done_per_cmd", done_seen, 2);

    // Burst write with address wrap
    we_log.delete();
    do_write(9'h1F0, 3, 32'h2000, 0);
    chki("wrap_cnt", we_log.size(), 4);
    if (we_log.size() == 4) begin
      chki("wrap_a0", int'(we_log[0]), 9'h1F0);
      chki("wrap_a1", int'(we_log[1]), 9'h000);
      chki("wrap_a2", int'(we_log[2]), 9'h010);
      chki("wrap_a3", int'(we_log[3]), 9'h020);
    end
    chki("lit_mem000", int'(mem_arr[9'h000]), 32'h2010);

    // Read backpressure
    do_read(9'h1F0, 1, 5, 0, blk);
    chki("lit_bp_w0", int'(blk[31:0]), 32'h2000);

    // Write stall
    do_write(9'h040, 0, 32'h3000, 7);

    // Reset during WR_PULSE of block 2 of 4
    d0 = done_seen;
    exp_wr.push_back(wr_t'{9'h100, make_blk(32'h4000)});
    for (int i = 0; i < WORDS; i++) shadow[9'h100 + i] = 32'(32'h4000 + i);
    exp_done++;
    issue_cmd(1'b1, 9'h100, 4'd3, acc);
    feed_block(make_blk(32'h4000), 0);
    feed_block(make_blk(32'h4010), 0);
    chki("we_before_rst", int'(mem_we), 1);
    #2 reset = 1'b0;
    #1;
    chki("rst_mid_we", int'(mem_we), 0);
    chki("rst_mid_cmd_ready", int'(cmd_ready), 1);
    chki("rst_mid_busy", int'(busy), 0);
    chki("rst_mid_done", int'(done), 0);
    exp_wr.delete();
    exp_done = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chki("rst_mid_no_done", done_seen, d0);
    chki("lit_mem110_unwritten", int'(mem_arr[9'h110]), 32'hA500_0110);
    do_write(9'h080, 0, 32'h5000, 0);
    do_read(9'h080, 0, 0, 0, blk);
    chki("lit_post_rst_w0", int'(blk[31:0]), 32'h5000);

    // Command ignored while busy
    we_log.delete();
    do_read(9'h000, 1, 0, 1, blk);
    repeat (10) @(posedge clk);
    #1;
    chki("ghost_no_we", we_log.size(), 0);
    chki("ghost_idle", int'(busy), 0);
    chki("exp_wr_drained", exp_wr.size(), 0);
    chki("exp_rd_drained", exp_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
